set_count_gen: RTL and testbench

- Parametrised successor to the contest SET engine.
- Holds NC circles on a GRID x GRID integer lattice, with lattice coordinates 1..GRID on each axis.
- Counts the lattice points that satisfy a selected set expression over the circles.
- Adds configurable grid size, configurable circle count and three-bit modes (N-ary set operations); it sits behind the same en/busy/valid handshake.

---
 rtl/set_gen_pkg.sv | 59 +++++
 rtl/set_circle_member.sv | 41 ++++
 rtl/set_count_gen.sv | 125 ++++++++++++
 tb/tb_set_count_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/set_gen_pkg.sv
// Shared types and helpers for the lattice set-count engine.
package set_gen_pkg;

    // Widest supported circle count; membership vectors are padded to this.
    localparam int MAX_NC = 8;

    typedef enum logic [2:0] {
        MODE_A   = 3'd0,
        MODE_OR  = 3'd1,
        MODE_XOR = 3'd2,
        MODE_AND = 3'd3,
        MODE_ONE = 3'd4,
        MODE_TWO = 3'd5,
        MODE_ALL = 3'd6,
        MODE_ANY = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bits needed to hold a count of 0..grid*grid.
    function automatic int cnt_width(input int grid);
        return $clog2(grid * grid + 1);
    endfunction

    // Evaluate the selected set expression; circles at index >= nc are empty.
    function automatic logic eval_mode(input logic [2:0] mode,
                                       input logic [MAX_NC-1:0] m,
                                       input int nc);
        logic [MAX_NC-1:0] mm;
        int n;
        logic res;
        mm = '0;
        n  = 0;
        for (int i = 0; i < MAX_NC; i++) begin
            if (i < nc) begin
                mm[i] = m[i];
                n     = n + int'(m[i]);
            end
        end
        case (mode_e'(mode))
            MODE_A:   res = mm[0];
            MODE_OR:  res = mm[0] | mm[1];
            MODE_XOR: res = mm[0] ^ mm[1];
            MODE_AND: res = mm[0] & mm[1];
            MODE_ONE: res = (n == 1);
            MODE_TWO: res = (n >= 2);
            MODE_ALL: res = (n == nc);
            MODE_ANY: res = (n >= 1);
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/set_circle_member.sv
// Combinational point-in-circle test: (x-xc)^2 + (y-yc)^2 <= r^2, full precision.
module set_circle_member #(
    parameter int CW = 4,
    parameter int RW = 4
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [CW-1:0] xc,
    input  logic [CW-1:0] yc,
    input  logic [RW-1:0] r,
    output logic          in
);
    localparam int SQ_W  = 2 * CW + 2;
    localparam int SUM_W = 2 * CW + 3;
    localparam int R2_W  = 2 * RW;
    localparam int CMP_W = (SUM_W > R2_W) ? SUM_W : R2_W;

    logic signed [CW:0]     w_dx;
    logic signed [CW:0]     w_dy;
    logic signed [SQ_W-1:0] w_dx_ext;
    logic signed [SQ_W-1:0] w_dy_ext;
    logic signed [SQ_W-1:0] w_dx2;
    logic signed [SQ_W-1:0] w_dy2;
    logic        [SUM_W-1:0] w_sum;
    logic        [R2_W-1:0]  w_r_ext;
    logic        [R2_W-1:0]  w_r2;

    // Signed differences are one bit wider than the coordinates so no wrap occurs.
    assign w_dx     = $signed({1'b0, x}) - $signed({1'b0, xc});
    assign w_dy     = $signed({1'b0, y}) - $signed({1'b0, yc});
    assign w_dx_ext = SQ_W'(w_dx);
    assign w_dy_ext = SQ_W'(w_dy);
    assign w_dx2    = w_dx_ext * w_dx_ext;
    assign w_dy2    = w_dy_ext * w_dy_ext;
    // Squares are never negative, so the sum is formed unsigned with one carry bit.
    assign w_sum    = {1'b0, w_dx2} + {1'b0, w_dy2};
    assign w_r_ext  = R2_W'(r);
    assign w_r2     = w_r_ext * w_r_ext;
    assign in       = (CMP_W'(w_sum) <= CMP_W'(w_r2));

endmodule

// File: rtl/set_count_gen.sv
// Scans a GRID x GRID lattice one point per cycle and counts the points that
// satisfy the latched set expression over NC circles.
module set_count_gen
    import set_gen_pkg::*;
#(
    parameter int GRID  = 8,
    parameter int CW    = 4,
    parameter int RW    = 4,
    parameter int NC    = 3,
    parameter int CNT_W = cnt_width(GRID)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2*CW*NC-1:0]   central,
    input  logic [RW*NC-1:0]     radius,
    input  logic [2:0]           mode,
    output logic                 busy,
    output logic                 valid,
    output logic [CNT_W-1:0]     candidate
);
    state_e              r_state;
    logic [CW-1:0]       r_x;
    logic [CW-1:0]       r_y;
    logic [2*CW*NC-1:0]  r_central;
    logic [RW*NC-1:0]    r_radius;
    logic [2:0]          r_mode;
    logic [NC-1:0]       r_m;
    logic                r_mv;
    logic [CNT_W-1:0]    r_acc;
    logic [NC-1:0]       w_m;
    logic                w_accept;
    logic                w_hit;

    assign w_accept = en && !busy && (r_state == IDLE);
    assign w_hit    = eval_mode(r_mode, MAX_NC'(r_m), NC);

    // One distance test per circle against the current scan point.
    for (genvar g = 0; g < NC; g++) begin : g_member
        set_circle_member #(
            .CW (CW),
            .RW (RW)
        ) u_member (
            .x  (r_x),
            .y  (r_y),
            .xc (r_central[2*CW*(NC-g)-1 -: CW]),
            .yc (r_central[2*CW*(NC-g)-CW-1 -: CW]),
            .r  (r_radius[RW*(NC-g)-1 -: RW]),
            .in (w_m[g])
        );
    end

    // Job parameters are captured at accept so the inputs may change freely afterwards.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_central <= central;
            r_radius  <= radius;
            r_mode    <= mode;
        end
    end

    // Membership stage: one register between the distance test and the accumulate.
    always_ff @(posedge clk) begin
        r_m <= w_m;
    end

    // Control FSM: scan counters, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_x       <= CW'(1);
            r_y       <= CW'(1);
            r_mv      <= 1'b0;
            r_acc     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
        end else begin
            valid <= 1'b0;
            r_mv  <= (r_state == SCAN);
            if (r_mv && w_hit) begin
                r_acc <= r_acc + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    // The result strobe cycle is spent in IDLE; busy drops with it.
                    if (valid) begin
                        busy <= 1'b0;
                    end
                    if (w_accept) begin
                        r_state <= SCAN;
                        busy    <= 1'b1;
                        r_x     <= CW'(1);
                        r_y     <= CW'(1);
                        r_acc   <= '0;
                    end
                end
                SCAN: begin
                    if (r_x == CW'(GRID)) begin
                        r_x <= CW'(1);
                        if (r_y == CW'(GRID)) begin
                            r_state <= FLUSH;
                        end else begin
                            r_y <= r_y + CW'(1);
                        end
                    end else begin
                        r_x <= r_x + CW'(1);
                    end
                end
                FLUSH: begin
                    r_state <= DONE;
                end
                DONE: begin
                    valid     <= 1'b1;
                    candidate <= r_acc;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_count_gen.sv
// Self-checking bench for set_count_gen: directed cases plus random jobs
// checked against a point-by-point lattice model.
module tb_set_count_gen;
    localparam int GRID  = 8;
    localparam int CW    = 4;
    localparam int RW    = 4;
    localparam int NC    = 3;
    localparam int CNT_W = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en  = 1'b0;
    logic [2*CW*NC-1:0] central = '0;
    logic [RW*NC-1:0]   radius  = '0;
    logic [2:0]         mode    = '0;
    logic               busy;
    logic               valid;
    logic [CNT_W-1:0]   candidate;

    logic               en1 = 1'b0;
    logic [2*CW-1:0]    central1 = '0;
    logic [RW-1:0]      radius1  = '0;
    logic [2:0]         mode1    = '0;
    logic               busy1;
    logic               valid1;
    logic [CNT_W-1:0]   candidate1;

    int n_cmp = 0;
    int n_mis = 0;
    int jx[3];
    int jy[3];
    int jr[3];
    int jmode;

    always #5 clk = ~clk;

    set_count_gen #(.GRID(GRID), .CW(CW), .RW(RW), .NC(NC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
    );

    set_count_gen #(.GRID(GRID), .CW(CW), .RW(RW), .NC(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .central(central1), .radius(radius1),
        .mode(mode1), .busy(busy1), .valid(valid1), .candidate(candidate1)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Lattice model: test every point against every circle and apply the set rule.
    function automatic int ref_count(input int md);
        int cnt = 0;
        for (int y = 1; y <= GRID; y++) begin
            for (int x = 1; x <= GRID; x++) begin
                bit in [3];
                int n = 0;
                bit hit;
                for (int i = 0; i < NC; i++) begin
                    in[i] = ((x - jx[i]) ** 2 + (y - jy[i]) ** 2) <= jr[i] ** 2;
                    n += in[i] ? 1 : 0;
                end
                case (md)
                    0: hit = in[0];
                    1: hit = in[0] || in[1];
                    2: hit = in[0] != in[1];
                    3: hit = in[0] && in[1];
                    4: hit = (n == 1);
                    5: hit = (n >= 2);
                    6: hit = (n == NC);
                    default: hit = (n >= 1);
                endcase
                if (hit) cnt++;
            end
        end
        return cnt;
    endfunction

    task automatic set_job(input int ax, ay, ar, bx, by, br, cx, cy, cr, md);
        jx[0] = ax; jy[0] = ay; jr[0] = ar;
        jx[1] = bx; jy[1] = by; jr[1] = br;
        jx[2] = cx; jy[2] = cy; jr[2] = cr;
        jmode = md;
    endtask

    task automatic drive_inputs();
        central = '0;
        radius  = '0;
        for (int i = 0; i < NC; i++) begin
            central[2*CW*(NC-i)-1 -: CW]    = CW'(jx[i]);
            central[2*CW*(NC-i)-CW-1 -: CW] = CW'(jy[i]);
            radius[RW*(NC-i)-1 -: RW]       = RW'(jr[i]);
        end
        mode = 3'(jmode);
    endtask

    task automatic scramble_inputs();
        central = (2*CW*NC)'($urandom);
        radius  = (RW*NC)'($urandom);
        mode    = 3'($urandom);
    endtask

    task automatic run_job(input string tag, input int exp_cnt, input bit pulse);
        int lat = 0;
        bit seen = 0;
        int prev_cand;
        @(negedge clk);
        drive_inputs();
        en = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_busy_at_accept"}, int'(busy), 1);
        prev_cand = int'(candidate);
        en = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            en = 1'b0;
            if (valid) begin
                seen = 1;
                lat  = k;
            end else begin
                if (k == 30) check_eq({tag, "_cand_held"}, int'(candidate), prev_cand);
                if (pulse && k == 10) begin
                    scramble_inputs();
                    en = 1'b1;
                end
            end
        end
        check_eq({tag, "_latency"}, lat, GRID * GRID + 2);
        check_eq({tag, "_count"}, int'(candidate), exp_cnt);
        check_eq({tag, "_busy_with_valid"}, int'(busy), 1);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_one_cycle"}, int'(valid), 0);
        check_eq({tag, "_busy_fall"}, int'(busy), 0);
        check_eq({tag, "_cand_hold"}, int'(candidate), exp_cnt);
    endtask

    task automatic run_nc1(input string tag, input int md, input int exp_cnt);
        bit seen = 0;
        @(negedge clk);
        central1 = {4'd4, 4'd4};
        radius1  = 4'd2;
        mode1    = 3'(md);
        en1      = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (valid1) seen = 1;
        end
        check_eq({tag, "_seen"}, int'(seen), 1);
        check_eq({tag, "_count"}, int'(candidate1), exp_cnt);
        @(posedge clk);
    endtask

    initial begin
        int vcount;
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_cand", int'(candidate), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        set_job(4, 4, 2, 1, 1, 0, 1, 1, 0, 0);
        run_job("a_r2", 13, 0);

        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 3); run_job("and", 5, 0);
        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 1); run_job("or", 21, 0);
        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 2); run_job("xor", 16, 0);
        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 4); run_job("one", 17, 0);
        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 5); run_job("two", 5, 0);
        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 6); run_job("all", 0, 0);

        set_job(1, 1, 2, 1, 1, 0, 1, 1, 0, 0); run_job("corner", 6, 0);
        set_job(0, 0, 0, 1, 1, 0, 1, 1, 0, 0); run_job("offgrid", 0, 0);
        set_job(4, 4, 15, 1, 1, 0, 1, 1, 0, 7); run_job("bigr", 64, 0);

        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 1); run_job("en_ignored", 21, 1);
        set_job(4, 4, 2, 6, 4, 2, 1, 1, 0, 4); run_job("back2back", 17, 0);

        for (int t = 0; t < 10; t++) begin
            set_job($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 6),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 6),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 6),
                    $urandom_range(0, 7));
            run_job($sformatf("rand%0d_m%0d", t, jmode), ref_count(jmode), t[0]);
        end

        // Abort a job with reset part-way through the scan.
        @(negedge clk);
        set_job(4, 4, 2, 1, 1, 0, 1, 1, 0, 0);
        drive_inputs();
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_valid", int'(valid), 0);
        check_eq("abort_cand", int'(candidate), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        check_eq("abort_no_valid", vcount, 0);
        run_job("after_abort", 13, 0);

        run_nc1("nc1_and", 3, 0);
        run_nc1("nc1_or", 1, 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
